// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Single-slave SPI master, mode 0 (CPOL=0, CPHA=0). Each request produces one
// frame of DATA_W bits framed by SPI_CSN. The frame has four timed phases of
// H = sclk_divider+1 clk cycles per half-period:
//   SETUP (1 half-period, SCLK low, first MOSI bit presented)
//   XFER  (2*DATA_W half-periods, DATA_W SCLK pulses)
//   HOLD  (1 half-period, SCLK low)
//   DONE  (1 clk cycle: CSN released, finish pulse(s), rx_rd_data loaded)
// The divider is captured when the frame starts, so changing it mid-frame has
// no effect on that frame.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   sclk_divider[7:0]     SCLK half-period minus one, in clk cycles
//   wr_en / rd_en         write / read request (both = full duplex)
//   tx_wr_data[DATA_W]    write payload, captured at request
//   wr_finish/rd_finish   one-cycle done pulses
//   rx_rd_data[DATA_W]    last frame received on a read transaction
//   SPI_SCLK/CSN/MOSI     SPI outputs, SPI_MISO SPI input
//
// Build option: define SPI_LSB_FIRST_EN to shift LSB first on both MOSI and
// MISO; timing is identical in either bit order.
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        sclk_divider,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] tx_wr_data,
    output logic              wr_finish,
    output logic              rd_finish,
    output logic [DATA_W-1:0] rx_rd_data,
    output logic              SPI_SCLK,
    output logic              SPI_CSN,
    output logic              SPI_MOSI,
    input  logic              SPI_MISO
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int HALF_W = $clog2(2 * DATA_W);
    // Even half-periods are SCLK high, odd ones SCLK low.
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_W - 1);
    localparam logic [HALF_W-1:0] LAST_FALL = HALF_W'(2 * DATA_W - 2);

    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        div_q, div_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              sclk_q, sclk_d;
    logic              csn_q, csn_d;
    logic              mosi_q, mosi_d;
    logic              wr_finish_q, wr_finish_d;
    logic              rd_finish_q, rd_finish_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    // Bit-order dependent helpers.
    logic              tx_first_bit;
    logic [DATA_W-1:0] tx_shifted;
    logic              tx_next_bit;
    logic [DATA_W-1:0] rx_inserted;

`ifdef SPI_LSB_FIRST_EN
    assign tx_first_bit = tx_wr_data[0];
    assign tx_shifted   = tx_q >> 1;
    assign tx_next_bit  = tx_q[1];
    assign rx_inserted  = {SPI_MISO, rx_sh_q[DATA_W-1:1]};
`else
    assign tx_first_bit = tx_wr_data[DATA_W-1];
    assign tx_shifted   = tx_q << 1;
    assign tx_next_bit  = tx_q[DATA_W-2];
    assign rx_inserted  = {rx_sh_q[DATA_W-2:0], SPI_MISO};
`endif

    logic phase_end;
    assign phase_end = (cnt_q == div_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        half_d      = half_q;
        tx_d        = tx_q;
        rx_sh_d     = rx_sh_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        sclk_d      = sclk_q;
        csn_d       = csn_q;
        mosi_d      = mosi_q;
        wr_finish_d = 1'b0;
        rd_finish_d = 1'b0;
        rx_data_d   = rx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_en || rd_en) begin
                    state_d = ST_SETUP;
                    csn_d   = 1'b0;
                    div_d   = sclk_divider;
                    cnt_d   = 8'd0;
                    half_d  = '0;
                    wr_d    = wr_en;
                    rd_d    = rd_en;
                    rx_sh_d = '0;
                    // Read-only frames shift out zeros.
                    tx_d    = wr_en ? tx_wr_data : '0;
                    mosi_d  = wr_en ? tx_first_bit : 1'b0;
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    state_d = ST_XFER;
                    cnt_d   = 8'd0;
                    half_d  = '0;
                    sclk_d  = 1'b1;
                    rx_sh_d = rx_inserted;  // sample with the rising edge
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_XFER: begin
                if (phase_end) begin
                    cnt_d = 8'd0;
                    if (half_q == LAST_HALF) begin
                        state_d = ST_HOLD;
                    end else begin
                        half_d = half_q + HALF_W'(1);
                        if (half_q[0]) begin
                            sclk_d  = 1'b1;
                            rx_sh_d = rx_inserted;
                        end else begin
                            sclk_d = 1'b0;
                            // The last bit stays on MOSI through HOLD.
                            if (half_q != LAST_FALL) begin
                                tx_d   = tx_shifted;
                                mosi_d = tx_next_bit;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    state_d     = ST_DONE;
                    cnt_d       = 8'd0;
                    csn_d       = 1'b1;
                    mosi_d      = 1'b0;
                    wr_finish_d = wr_q;
                    rd_finish_d = rd_q;
                    if (rd_q) begin
                        rx_data_d = rx_sh_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                csn_d   = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            div_q       <= 8'd0;
            half_q      <= '0;
            tx_q        <= '0;
            rx_sh_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            sclk_q      <= 1'b0;
            csn_q       <= 1'b1;
            mosi_q      <= 1'b0;
            wr_finish_q <= 1'b0;
            rd_finish_q <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            half_q      <= half_d;
            tx_q        <= tx_d;
            rx_sh_q     <= rx_sh_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            sclk_q      <= sclk_d;
            csn_q       <= csn_d;
            mosi_q      <= mosi_d;
            wr_finish_q <= wr_finish_d;
            rd_finish_q <= rd_finish_d;
            rx_data_q   <= rx_data_d;
        end
    end

    assign SPI_SCLK   = sclk_q;
    assign SPI_CSN    = csn_q;
    assign SPI_MOSI   = mosi_q;
    assign wr_finish  = wr_finish_q;
    assign rd_finish  = rd_finish_q;
    assign rx_rd_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//
// Directed bench for spi_master (DATA_W=8). A bus monitor / slave model on the
// falling clk edge measures each CSN-low window (SCLK pulses, SCLK period,
// CSN-low length, MOSI bits seen at SCLK rising edges) and drives MISO from a
// slave word, changing it after each SCLK falling edge. Each frame's expected
// result is queued when it is launched and popped when the frame ends.
// -----------------------------------------------------------------------------
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sclk_divider;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] tx_wr_data;
    logic       wr_finish;
    logic       rd_finish;
    logic [7:0] rx_rd_data;
    logic       SPI_SCLK;
    logic       SPI_CSN;
    logic       SPI_MOSI;
    logic       SPI_MISO = 1'b0;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk_divider (sclk_divider),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .tx_wr_data   (tx_wr_data),
        .wr_finish    (wr_finish),
        .rd_finish    (rd_finish),
        .rx_rd_data   (rx_rd_data),
        .SPI_SCLK     (SPI_SCLK),
        .SPI_CSN      (SPI_CSN),
        .SPI_MOSI     (SPI_MOSI),
        .SPI_MISO     (SPI_MISO)
    );

    // ---------------- monitor / slave model ----------------
    int         cyc = 0;
    logic       sclk_prev = 1'b0;
    logic       csn_prev = 1'b1;
    int         frame_start_cnt = 0;
    int         frame_done_cnt = 0;
    int         wr_fin_cnt = 0;
    int         rd_fin_cnt = 0;
    int         both_fin_cnt = 0;
    int         csn_low = 0;
    int         pulses = 0;
    int         last_rise = 0;
    int         per_min = 0;
    int         per_max = 0;
    logic [7:0] cap = 8'h00;
    logic       first_mosi = 1'b0;
    logic       mosi_or = 1'b0;
    logic [7:0] slave_word = 8'h00;
    logic [7:0] slave_sh = 8'h00;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        sclk_prev <= SPI_SCLK;
        csn_prev  <= SPI_CSN;
        if (wr_finish) wr_fin_cnt <= wr_fin_cnt + 1;
        if (rd_finish) rd_fin_cnt <= rd_fin_cnt + 1;
        if (wr_finish && rd_finish) both_fin_cnt <= both_fin_cnt + 1;
        if (!csn_prev && SPI_CSN) frame_done_cnt <= frame_done_cnt + 1;
        if (csn_prev && !SPI_CSN) begin
            frame_start_cnt <= frame_start_cnt + 1;
            csn_low  <= 1;
            pulses   <= 0;
            cap      <= 8'h00;
            mosi_or  <= SPI_MOSI;
            per_min  <= 1000000;
            per_max  <= 0;
            slave_sh <= slave_word;
`ifdef SPI_LSB_FIRST_EN
            SPI_MISO <= slave_word[0];
`else
            SPI_MISO <= slave_word[7];
`endif
        end else if (!SPI_CSN) begin
            csn_low <= csn_low + 1;
            mosi_or <= mosi_or | SPI_MOSI;
            if (SPI_SCLK && !sclk_prev) begin
                pulses <= pulses + 1;
`ifdef SPI_LSB_FIRST_EN
                cap <= {SPI_MOSI, cap[7:1]};
`else
                cap <= {cap[6:0], SPI_MOSI};
`endif
                if (pulses == 0) begin
                    first_mosi <= SPI_MOSI;
                end else begin
                    if (cyc - last_rise < per_min) per_min <= cyc - last_rise;
                    if (cyc - last_rise > per_max) per_max <= cyc - last_rise;
                end
                last_rise <= cyc;
            end
            if (!SPI_SCLK && sclk_prev) begin
`ifdef SPI_LSB_FIRST_EN
                slave_sh <= slave_sh >> 1;
                SPI_MISO <= slave_sh[1];
`else
                slave_sh <= slave_sh << 1;
                SPI_MISO <= slave_sh[6];
`endif
            end
        end
    end

    // ---------------- scoreboard / checking ----------------
    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] tx;
        logic [7:0] rx;
        int         h;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] rx_model = 8'h00;
    int         w0, r0, b0, d0, s0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic first_of(input logic [7:0] d);
`ifdef SPI_LSB_FIRST_EN
        return d[0];
`else
        return d[7];
`endif
    endfunction

    task automatic snap();
        w0 = wr_fin_cnt;
        r0 = rd_fin_cnt;
        b0 = both_fin_cnt;
        d0 = frame_done_cnt;
        s0 = frame_start_cnt;
    endtask

    task automatic launch(input logic wr, input logic rd, input logic [7:0] tx,
                          input logic [7:0] miso_w, input logic [7:0] div, input bit push);
        exp_t e;
        slave_word = miso_w;
        @(negedge clk);
        sclk_divider = div;
        tx_wr_data   = tx;
        wr_en        = wr;
        rd_en        = rd;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (push) begin
            e.wr = wr; e.rd = rd; e.tx = tx; e.rx = miso_w; e.h = int'(div) + 1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frame_done_cnt == d0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check("frame_end_seen", 32'(frame_done_cnt != d0), 32'd1);
    endtask

    task automatic check_frame();
        exp_t e;
        logic [7:0] mosi_exp;
        e = sb.pop_front();
        mosi_exp = e.wr ? e.tx : 8'h00;
        $display("frame wr=%0b rd=%0b tx=%02h miso=%02h H=%0d : mosi=%02h rx=%02h pulses=%0d csn_low=%0d",
                 e.wr, e.rd, e.tx, e.rx, e.h, cap, rx_rd_data, pulses, csn_low);
        check("sclk_pulses", 32'(pulses), 32'd8);
        check("sclk_period_min", 32'(per_min), 32'(2 * e.h));
        check("sclk_period_max", 32'(per_max), 32'(2 * e.h));
        check("csn_low_cycles", 32'(csn_low), 32'(18 * e.h));
        check("mosi_bits", 32'(cap), 32'(mosi_exp));
        check("mosi_first_bit", 32'(first_mosi), 32'(first_of(mosi_exp)));
        check("mosi_any_high", 32'(mosi_or), 32'(|mosi_exp));
        check("wr_finish_pulses", 32'(wr_fin_cnt - w0), 32'(e.wr));
        check("rd_finish_pulses", 32'(rd_fin_cnt - r0), 32'(e.rd));
        check("finish_same_cycle", 32'(both_fin_cnt - b0), 32'(e.wr && e.rd));
        if (e.rd) rx_model = e.rx;
        check("rx_rd_data", 32'(rx_rd_data), 32'(rx_model));
    endtask

    task automatic run_frame(input logic wr, input logic rd, input logic [7:0] tx,
                             input logic [7:0] miso_w, input logic [7:0] div);
        snap();
        launch(wr, rd, tx, miso_w, div, 1'b1);
        wait_frame();
        check_frame();
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        sclk_divider = 8'd1;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        tx_wr_data   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_csn", 32'(SPI_CSN), 32'd1);
        check("reset_sclk", 32'(SPI_SCLK), 32'd0);
        check("reset_mosi", 32'(SPI_MOSI), 32'd0);
        check("reset_finish", 32'({wr_finish, rd_finish}), 32'd0);
        check("reset_rx", 32'(rx_rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // write, read, full duplex at H=2
        run_frame(1'b1, 1'b0, 8'hA5, 8'h00, 8'd1);
        run_frame(1'b0, 1'b1, 8'hFF, 8'h3C, 8'd1);
        run_frame(1'b1, 1'b1, 8'h5A, 8'hC3, 8'd1);

        // busy: re-request and divider change mid-frame have no effect
        snap();
        launch(1'b1, 1'b0, 8'h96, 8'h00, 8'd1, 1'b1);
        repeat (10) @(negedge clk);
        sclk_divider = 8'd5;
        tx_wr_data   = 8'hFF;
        wr_en        = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        wait_frame();
        check_frame();
        repeat (30) @(posedge clk);
        check("busy_no_extra_frame", 32'(frame_start_cnt - s0), 32'd1);

        // sclk_divider=0 -> H=1, then back-to-back frames
        run_frame(1'b1, 1'b1, 8'hC5, 8'h69, 8'd0);
        run_frame(1'b1, 1'b1, 8'h01, 8'h01, 8'd0);
        check("rx_bit0_from_first_sample", 32'(rx_rd_data[0]), 32'd1);

        // reset abort after the 3rd SCLK pulse
        snap();
        launch(1'b1, 1'b1, 8'hAA, 8'hFF, 8'd1, 1'b0);
        n = 0;
        while (!(frame_start_cnt != s0 && pulses == 3) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check("abort_third_pulse_seen", 32'(pulses), 32'd3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        rx_model = 8'h00;
        check("abort_csn", 32'(SPI_CSN), 32'd1);
        check("abort_sclk", 32'(SPI_SCLK), 32'd0);
        check("abort_mosi", 32'(SPI_MOSI), 32'd0);
        check("abort_rx", 32'(rx_rd_data), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        check("abort_no_wr_finish", 32'(wr_fin_cnt - w0), 32'd0);
        check("abort_no_rd_finish", 32'(rd_fin_cnt - r0), 32'd0);
        $display("reset abort: csn=%0b sclk=%0b finishes=%0d", SPI_CSN, SPI_SCLK,
                 (wr_fin_cnt - w0) + (rd_fin_cnt - r0));

        // frames after the abort complete normally
        run_frame(1'b1, 1'b0, 8'h3E, 8'h00, 8'd1);
        run_frame(1'b0, 1'b1, 8'h00, 8'hB7, 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
